// File: rtl/hazard_ctrl.sv
// RAW hazard/forwarding control for the IF/ID/EX/WB pipe; all outputs combinational, zero latency.
// Backpressure: stall/ex_hold/bubble freeze upstream stages. Optional stall counter: HAZARD_CTRL_PERF_EN.
module hazard_ctrl #(
  parameter int RW      = 3,
  parameter int MUL_LAT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic          id_rs1_en,
  input  logic          id_rs2_en,
  input  logic [RW-1:0] id_rd,
  input  logic          id_rd_en,
  input  logic          id_load,
  input  logic          id_mul,
  output logic          stall,
  output logic          ex_hold,
  output logic          bubble,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          ex_busy
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [15:0]   stall_cycles
`endif
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [3:0] MCNT_LOAD = 4'(MUL_LAT - 1);

  state_e        state_q, state_d;
  logic [3:0]    mcnt_q, mcnt_d;
  logic          ex_v_q, ex_v_d;
  logic [RW-1:0] ex_rd_q, ex_rd_d;
  logic          ex_rd_en_q, ex_rd_en_d;
  logic          ex_load_q, ex_load_d;
  logic          wb_v_q, wb_v_d;
  logic [RW-1:0] wb_rd_q, wb_rd_d;
  logic          wb_rd_en_q, wb_rd_en_d;

  logic hit_ex_a, hit_ex_b, hit_wb_a, hit_wb_b;

  // Register 0 is hardwired zero, so it can never be a real dependency.
  function automatic logic hit(input logic slot_v, input logic slot_rd_en,
                               input logic [RW-1:0] slot_rd,
                               input logic [RW-1:0] rs, input logic rs_en,
                               input logic vld);
    return vld && rs_en && slot_v && slot_rd_en && (slot_rd == rs) && (rs != '0);
  endfunction

  always_comb begin
    hit_ex_a = hit(ex_v_q, ex_rd_en_q, ex_rd_q, id_rs1, id_rs1_en, id_valid);
    hit_ex_b = hit(ex_v_q, ex_rd_en_q, ex_rd_q, id_rs2, id_rs2_en, id_valid);
    hit_wb_a = hit(wb_v_q, wb_rd_en_q, wb_rd_q, id_rs1, id_rs1_en, id_valid);
    hit_wb_b = hit(wb_v_q, wb_rd_en_q, wb_rd_q, id_rs2, id_rs2_en, id_valid);

    stall   = 1'b0;
    ex_hold = 1'b0;
    bubble  = 1'b0;
    if (state_q == BUSY) begin
      stall   = 1'b1;
      ex_hold = 1'b1;
    end else if (ex_load_q && (hit_ex_a || hit_ex_b)) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end

    // A load result does not exist until WB, so an EX match on a load never forwards.
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!stall) begin
      if (hit_ex_a && !ex_load_q) fwd_a = 2'b01;
      else if (hit_wb_a)          fwd_a = 2'b10;
      if (hit_ex_b && !ex_load_q) fwd_b = 2'b01;
      else if (hit_wb_b)          fwd_b = 2'b10;
    end

    ex_busy = (state_q == BUSY);

    ex_v_d     = ex_v_q;
    ex_rd_d    = ex_rd_q;
    ex_rd_en_d = ex_rd_en_q;
    ex_load_d  = ex_load_q;
    wb_v_d     = wb_v_q;
    wb_rd_d    = wb_rd_q;
    wb_rd_en_d = wb_rd_en_q;
    mcnt_d     = mcnt_q;

    if (ex_hold) begin
      wb_v_d = 1'b0;
      mcnt_d = mcnt_q - 4'd1;
    end else begin
      wb_v_d     = ex_v_q;
      wb_rd_d    = ex_rd_q;
      wb_rd_en_d = ex_rd_en_q;
      if (bubble) begin
        ex_v_d     = 1'b0;
        ex_rd_d    = '0;
        ex_rd_en_d = 1'b0;
        ex_load_d  = 1'b0;
        mcnt_d     = 4'd0;
      end else begin
        ex_v_d     = id_valid;
        ex_rd_d    = id_rd;
        ex_rd_en_d = id_rd_en;
        ex_load_d  = id_load;
        // The final EX cycle of a multi-cycle op is left non-busy so it can forward.
        mcnt_d     = (id_valid && id_mul) ? MCNT_LOAD : 4'd0;
      end
    end

    state_d = (mcnt_d != 4'd0) ? BUSY : IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mcnt_q     <= 4'd0;
      ex_v_q     <= 1'b0;
      ex_rd_q    <= '0;
      ex_rd_en_q <= 1'b0;
      ex_load_q  <= 1'b0;
      wb_v_q     <= 1'b0;
      wb_rd_q    <= '0;
      wb_rd_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcnt_q     <= mcnt_d;
      ex_v_q     <= ex_v_d;
      ex_rd_q    <= ex_rd_d;
      ex_rd_en_q <= ex_rd_en_d;
      ex_load_q  <= ex_load_d;
      wb_v_q     <= wb_v_d;
      wb_rd_q    <= wb_rd_d;
      wb_rd_en_q <= wb_rd_en_d;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 16'hFFFF)) stall_cycles_d = stall_cycles_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cycles_q <= 16'd0;
    else     stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and forwarding controller for the 4-stage IF/ID/EX/WB integer pipeline. It keeps a shadow scoreboard of the instructions in EX and WB, detects read-after-write hazards against the instruction in ID, and decides how the datapath resolves each one: forward, stall with a bubble on load-use, or freeze while a multi-cycle ALU op is in EX. It drives the `stall` inputs of `if_stage`, `pipe_if_id` and `pipe_id_ex`, and the forwarding muxes in front of the ALU.

## Interface
- `RW`, 3: register address width.
- `MUL_LAT`, 3: EX-stage latency of a multi-cycle op. Legal range is 1..15; 1 means single-cycle.

- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `id_valid`, input, 1: the ID stage holds a valid instruction.
- `id_rs1`, `id_rs2`, input, RW: source register addresses.
- `id_rs1_en`, `id_rs2_en`, input, 1: the corresponding source is read.
- `id_rd`, input, RW: destination register.
- `id_rd_en`, input, 1: the instruction writes `id_rd`.
- `id_load`, input, 1: the result is available only in WB.
- `id_mul`, input, 1: multi-cycle ALU op.
- `stall`, output, 1: hold PC and IF/ID.
- `ex_hold`, output, 1: hold ID/EX and EX.
- `bubble`, output, 1: ID/EX loads a NOP this edge.
- `fwd_a`, `fwd_b`, output, 2: operand source. 00 is the ID operand, 01 is the EX result, 10 is the WB result, and 11 is never driven.
- `ex_busy`, output, 1: a multi-cycle op is occupying EX.

## Operation
- **Registered state**
  - EX slot: `ex_v`, `ex_rd`, `ex_rd_en`, `ex_load`.
  - WB slot: `wb_v`, `wb_rd`, `wb_rd_en`.
  - 4-bit counter `mcnt`.
  - FSM state, either IDLE or BUSY. The FSM is BUSY exactly when `mcnt != 0`.
- **Hazard matching**
  - `hit_ex(rs)` is true when all of the following hold: `id_valid`, `rs_en`, `ex_v`, `ex_rd_en`, `ex_rd == rs`, and `rs != 0`.
  - `hit_wb(rs)` uses the same conditions against the WB slot.
  - Register 0 is hardwired zero. It never matches, so it never causes a forward or a stall.
- **Control decision, in priority order**
  1. BUSY: `stall=1`, `ex_hold=1`, `bubble=0`.
  2. Load-use, i.e. `ex_load` and (`hit_ex(rs1)` or `hit_ex(rs2)`): `stall=1`, `ex_hold=0`, `bubble=1`.
  3. Otherwise: all three are 0.
- **Forwarding**
  - For each operand: if `hit_ex` and not `ex_load`, select 01. Otherwise, if `hit_wb`, select 10. Otherwise select 00.
  - EX has priority over WB when both match.
  - `fwd_a` and `fwd_b` are forced to 00 whenever `stall=1`.
- **Slot update when `ex_hold=1`**
  - The EX slot is unchanged.
  - `wb_v` is set to 0.
  - `mcnt` decrements by 1.
- **Slot update otherwise**
  - The WB slot takes the EX slot.
  - If `bubble=1`, the EX slot is invalidated. Otherwise it takes `{id_valid, id_rd, id_rd_en, id_load}`.
  - If the entering instruction is valid and has `id_mul` set, `mcnt` is loaded with MUL_LAT−1. The op therefore occupies EX for MUL_LAT cycles, and its final cycle is non-BUSY so it can forward.
- `ex_busy` equals BUSY.
- A mul with `rd=0`, or with `id_rd_en=0`, still freezes the pipe for its full latency.
- With `id_valid=0`, a bubble enters EX and no stall is raised.

## Timing
- All outputs are combinational from the registered state and the ID inputs. There is no output register.
- A decision takes effect in the same cycle that the ID inputs are presented.
- Load-use costs exactly 1 stall cycle. After it, the producer is in WB and the operand is forwarded with 10.
- A multi-cycle op costs MUL_LAT−1 frozen cycles.
- **Reset**
  - Reset is asynchronous. All slots are invalidated, `mcnt` is 0 and the FSM is IDLE.
  - During and after reset: `stall=0`, `ex_hold=0`, `bubble=0`, `fwd_a=fwd_b=00`, `ex_busy=0`.
  - Reset asserted in the middle of a multi-cycle op aborts it immediately and does not resume it.
- A load-use hazard cannot be detected while BUSY. It is evaluated in the first cycle after BUSY ends.

## Configuration
- **`HAZARD_CTRL_PERF_EN` defined**
  - Adds the output port `stall_cycles`, 16 bits.
  - It increments on every clock edge where `stall=1` and saturates at 0xFFFF.
  - Reset clears it to 0.
- **`HAZARD_CTRL_PERF_EN` not defined**
  - The port and the counter are absent.
  - Behaviour is otherwise identical.

## Test plan
1. **EX forward.** `ADD rd=3`, then `SUB rs1=3` → while SUB is in ID: `fwd_a=01`, `stall=0`, `bubble=0`.
2. **WB forward.** `rd=3`, an unrelated instruction, then `rs2=3` → `fwd_b=10`. Repeat with producers of `rd=4` in both EX and WB and `rs1=4` → `fwd_a=01`.
3. **Load-use.** `LOAD rd=2`, then `rs1=2` → one cycle of `stall=1`, `bubble=1`, `fwd_a=00`. In the next cycle, `fwd_a=10`. If the perf macro is defined, `stall_cycles=1`.
4. **Multi-cycle op, `MUL_LAT=3`.** `MUL rd=5`, then `rs1=5` → two cycles of `stall=1`, `ex_hold=1`, `ex_busy=1`, then `fwd_a=01` with stall released. During the frozen cycles, `wb_v=0` is observable as no WB forward.
5. **Register 0.** `rd=0` producer followed by a `rs1=0` consumer, including a `rd=0` load → `fwd_a=00` and no stall.
6. **Reset mid-operation.** Assert `rst` on the 2nd BUSY cycle of a `MUL_LAT=5` op → all outputs go to 0 asynchronously. After release, a dependent instruction sees `fwd=00`, and `stall_cycles=0`.
